lsu_pipe: RTL and testbench

LSU_PIPE -- requirements
Module: lsu_pipe

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_lane_align.sv | 60 ++++++
 rtl/lsu_pipe.sv | 194 +++++++++++++++++++
 tb/tb_lsu_pipe.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store pipe: ops, FSM states, fault codes and funct3 sizes.
package lsu_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'd0,
    FLT_MISALIGN = 2'd1,
    FLT_BUS      = 2'd2,
    FLT_SIZE     = 2'd3
  } fault_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane logic: load extract/extend, store replicate/strobe, size legality and alignment.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                 funct3,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  logic                       store,
  input  logic [XLEN-1:0]            wdata,
  input  logic [XLEN-1:0]            rdata,
  output logic [XLEN-1:0]            ldata,
  output logic [XLEN-1:0]            sdata,
  output logic [XLEN/8-1:0]          be,
  output logic [1:0]                 size,
  output logic                       misalign,
  output logic                       illegal
);

  localparam int BW = XLEN / 8;

  logic [2:0]      off3;
  logic [XLEN-1:0] sh;
  logic [7:0]      mask;

  always_comb begin
    size  = funct3[1:0];
    off3  = 3'(off);
    // stores only have SB/SH/SW/SD; the unsigned-load codes are undefined for them
    illegal = (store && funct3[2]) || (funct3 == 3'b111) ||
              ((XLEN == 32) && ((funct3 == F3_D) || (funct3 == F3_WU)));

    case (size)
      2'd1:    misalign = off3[0];
      2'd2:    misalign = (off3[1:0] != 2'b00);
      2'd3:    misalign = (off3 != 3'b000);
      default: misalign = 1'b0;
    endcase

    sh = rdata >> {off3, 3'b000};
    case (funct3)
      F3_B:    ldata = XLEN'($signed(sh[7:0]));
      F3_H:    ldata = XLEN'($signed(sh[15:0]));
      F3_W:    ldata = XLEN'($signed(sh[31:0]));
      F3_BU:   ldata = XLEN'(sh[7:0]);
      F3_HU:   ldata = XLEN'(sh[15:0]);
      F3_WU:   ldata = XLEN'(sh[31:0]);
      default: ldata = sh;
    endcase

    case (size)
      2'd0: begin sdata = {BW{wdata[7:0]}};       mask = 8'h01; end
      2'd1: begin sdata = {(BW/2){wdata[15:0]}};  mask = 8'h03; end
      2'd2: begin sdata = {(BW/4){wdata[31:0]}};  mask = 8'h0F; end
      default: begin sdata = wdata;               mask = 8'hFF; end
    endcase
    be = BW'(mask << off3);
  end

endmodule

// File: rtl/lsu_pipe.sv
// Load/store unit: one outstanding bus access, checked at accept, result staged onto wb_*.
//   state  | meaning
//   S_IDLE | ready for a request from EX; faults and NONE ops answer from here
//   S_REQ  | dreq held with stable address/data until dbusy drops
//   S_WAIT | load accepted by bus, waiting for dready_n low or timeout
module lsu_pipe
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [4:0]        in_rd,
  input  logic              in_regwrite,
  input  logic [1:0]        in_memtoreg,
  input  logic [31:0]       in_pcp4,
  input  logic              flush,
  output logic [31:0]       daddr,
  output logic              dreq,
  output logic              dwrite,
  output logic [1:0]        dsize,
  output logic [XLEN-1:0]   dwdata,
  output logic [XLEN/8-1:0] dbe,
  input  logic [XLEN-1:0]   drdata,
  input  logic              dbusy,
  input  logic              dready_n,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic [4:0]        wb_rd,
  output logic [1:0]        wb_memtoreg,
  output logic [31:0]       wb_alu,
  output logic [31:0]       wb_pcp4,
  output logic [XLEN-1:0]   wb_ldata,
  output logic [1:0]        wb_fault
);

  localparam int BW = XLEN / 8;
  localparam int OW = $clog2(BW);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state;
  logic [CW-1:0]   tmr;
  logic            killed;
  logic [2:0]      r_funct3;
  logic [OW-1:0]   r_off;
  logic [31:0]     r_addr, r_pcp4;
  logic [4:0]      r_rd;
  logic            r_regwrite;
  logic [1:0]      r_memtoreg;

  logic            idle, is_mem;
  logic [2:0]      ln_f3;
  logic [OW-1:0]   ln_off;
  logic            ln_store, ln_misalign, ln_illegal;
  logic [XLEN-1:0] ln_ldata, ln_sdata;
  logic [BW-1:0]   ln_be;
  logic [1:0]      ln_size;

  assign idle     = (state == S_IDLE);
  assign in_ready = idle;
  assign is_mem   = (in_op == OP_LOAD) || (in_op == OP_STORE);
  // one lane block serves both: checks on the incoming request in IDLE, extraction of the held load later
  assign ln_f3    = idle ? in_funct3 : r_funct3;
  assign ln_off   = idle ? in_addr[OW-1:0] : r_off;
  assign ln_store = idle && (in_op == OP_STORE);

  lsu_lane_align #(.XLEN(XLEN)) u_lane (
    .funct3   (ln_f3),
    .off      (ln_off),
    .store    (ln_store),
    .wdata    (in_wdata),
    .rdata    (drdata),
    .ldata    (ln_ldata),
    .sdata    (ln_sdata),
    .be       (ln_be),
    .size     (ln_size),
    .misalign (ln_misalign),
    .illegal  (ln_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tmr         <= '0;
      killed      <= 1'b0;
      dreq        <= 1'b0;
      dwrite      <= 1'b0;
      dsize       <= '0;
      daddr       <= '0;
      dwdata      <= '0;
      dbe         <= '0;
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rd       <= '0;
      wb_memtoreg <= '0;
      wb_alu      <= '0;
      wb_pcp4     <= '0;
      wb_ldata    <= '0;
      wb_fault    <= '0;
      r_funct3    <= '0;
      r_off       <= '0;
      r_addr      <= '0;
      r_pcp4      <= '0;
      r_rd        <= '0;
      r_regwrite  <= 1'b0;
      r_memtoreg  <= '0;
    end else begin
      wb_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (in_valid && !flush) begin
            r_funct3   <= in_funct3;
            r_off      <= in_addr[OW-1:0];
            r_addr     <= in_addr;
            r_pcp4     <= in_pcp4;
            r_rd       <= in_rd;
            r_regwrite <= in_regwrite;
            r_memtoreg <= in_memtoreg;
            if (is_mem && !ln_illegal && !ln_misalign) begin
              state  <= S_REQ;
              killed <= 1'b0;
              dreq   <= 1'b1;
              dwrite <= ln_store;
              dsize  <= ln_size;
              daddr  <= in_addr & ~32'(BW - 1);
              dwdata <= ln_sdata;
              dbe    <= ln_store ? ln_be : '0;
            end else begin
              wb_valid    <= 1'b1;
              wb_regwrite <= is_mem ? 1'b0 : in_regwrite;
              wb_fault    <= !is_mem ? FLT_NONE : (ln_illegal ? FLT_SIZE : FLT_MISALIGN);
              wb_rd       <= in_rd;
              wb_memtoreg <= in_memtoreg;
              wb_alu      <= in_addr;
              wb_pcp4     <= in_pcp4;
            end
          end
        end
        S_REQ: begin
          if (flush && dbusy) begin
            dreq  <= 1'b0;
            state <= S_IDLE;
          end else if (!dbusy) begin
            dreq   <= 1'b0;
            killed <= flush;
            if (dwrite) begin
              state <= S_IDLE;
              if (!flush) begin
                wb_valid    <= 1'b1;
                wb_regwrite <= 1'b0;
                wb_fault    <= FLT_NONE;
                wb_rd       <= r_rd;
                wb_memtoreg <= r_memtoreg;
                wb_alu      <= r_addr;
                wb_pcp4     <= r_pcp4;
              end
            end else begin
              state <= S_WAIT;
              tmr   <= CW'(TIMEOUT - 1);
            end
          end
        end
        S_WAIT: begin
          if (flush) killed <= 1'b1;
          if (!dready_n || (tmr == '0)) begin
            state <= S_IDLE;
            tmr   <= '0;
            if (!killed && !flush) begin
              wb_valid    <= 1'b1;
              wb_regwrite <= !dready_n ? r_regwrite : 1'b0;
              wb_fault    <= !dready_n ? FLT_NONE : FLT_BUS;
              wb_rd       <= r_rd;
              wb_memtoreg <= r_memtoreg;
              wb_alu      <= r_addr;
              wb_pcp4     <= r_pcp4;
              if (!dready_n) wb_ldata <= ln_ldata;
            end
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_pipe.sv
// Directed bench for lsu_pipe: a 32-bit instance (TIMEOUT=8) and a 64-bit instance, scoreboarded writeback.
module tb_lsu_pipe;
  import lsu_pkg::*;

  typedef struct {
    logic [63:0] ld;
    logic        chk_ld;
    logic [1:0]  flt;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
  } exp_t;

  logic clk, rst, flush, dbusy, dready_n;
  logic [1:0] in_op;
  logic [2:0] in_funct3;
  logic [31:0] in_addr, in_pcp4;
  logic [4:0] in_rd;
  logic in_regwrite;
  logic [1:0] in_memtoreg;

  logic in_valid, in_ready, dreq, dwrite, wb_valid, wb_regwrite;
  logic [31:0] in_wdata, drdata, daddr, dwdata, wb_alu, wb_pcp4, wb_ldata;
  logic [3:0] dbe;
  logic [1:0] dsize, wb_memtoreg, wb_fault;
  logic [4:0] wb_rd;

  logic w_in_valid, w_in_ready, w_dreq, w_dwrite, w_wb_valid, w_wb_regwrite;
  logic [63:0] w_in_wdata, w_drdata, w_dwdata, w_wb_ldata;
  logic [31:0] w_daddr, w_wb_alu, w_wb_pcp4;
  logic [7:0] w_dbe;
  logic [1:0] w_dsize, w_wb_memtoreg, w_wb_fault;
  logic [4:0] w_wb_rd;

  int n_cmp = 0;
  int n_err = 0;
  exp_t q32[$];
  exp_t q64[$];

  lsu_pipe #(.XLEN(32), .TIMEOUT(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_pcp4(in_pcp4), .flush(flush),
    .daddr(daddr), .dreq(dreq), .dwrite(dwrite), .dsize(dsize), .dwdata(dwdata), .dbe(dbe),
    .drdata(drdata), .dbusy(dbusy), .dready_n(dready_n), .wb_valid(wb_valid),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_memtoreg(wb_memtoreg), .wb_alu(wb_alu),
    .wb_pcp4(wb_pcp4), .wb_ldata(wb_ldata), .wb_fault(wb_fault)
  );

  lsu_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_op(in_op),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(w_in_wdata), .in_rd(in_rd),
    .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_pcp4(in_pcp4), .flush(flush),
    .daddr(w_daddr), .dreq(w_dreq), .dwrite(w_dwrite), .dsize(w_dsize), .dwdata(w_dwdata),
    .dbe(w_dbe), .drdata(w_drdata), .dbusy(dbusy), .dready_n(dready_n), .wb_valid(w_wb_valid),
    .wb_regwrite(w_wb_regwrite), .wb_rd(w_wb_rd), .wb_memtoreg(w_wb_memtoreg), .wb_alu(w_wb_alu),
    .wb_pcp4(w_wb_pcp4), .wb_ldata(w_wb_ldata), .wb_fault(w_wb_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic expect_wb(input bit b64, input logic [63:0] ld, input logic chk_ld,
                           input logic [1:0] flt, input logic rw, input logic [4:0] rd,
                           input logic [31:0] alu);
    exp_t e;
    e.ld = ld; e.chk_ld = chk_ld; e.flt = flt; e.rw = rw; e.rd = rd; e.alu = alu;
    if (b64) q64.push_back(e); else q32.push_back(e);
  endtask

  task automatic issue(input bit b64, input logic [1:0] op, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [63:0] wd, input logic [4:0] rd,
                       input logic rw);
    in_op = op; in_funct3 = f3; in_addr = addr; in_wdata = wd[31:0]; w_in_wdata = wd;
    in_rd = rd; in_regwrite = rw; in_pcp4 = addr + 32'd4;
    if (b64) w_in_valid = 1'b1; else in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; w_in_valid = 1'b0;
  endtask

  task automatic do_load32(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] want);
    expect_wb(1'b0, {32'h0, want}, 1'b1, FLT_NONE, 1'b1, 5'd9, addr);
    drdata = rdata;
    issue(1'b0, OP_LOAD, f3, addr, 64'h0, 5'd9, 1'b1);
    @(negedge clk); dready_n = 1'b0;
    @(negedge clk); dready_n = 1'b1;
  endtask

  task automatic do_fault(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [1:0] flt);
    expect_wb(1'b0, 64'h0, 1'b0, flt, 1'b0, 5'd4, addr);
    issue(1'b0, op, f3, addr, 64'h1234, 5'd4, 1'b1);
    check("fault_no_dreq", dreq, 1'b0);
  endtask

  always @(negedge clk) begin : mon32
    exp_t e;
    if (!rst && wb_valid) begin
      if (q32.size() == 0) check("wb32_unexpected", wb_valid, 1'b0);
      else begin
        e = q32.pop_front();
        check("wb32_fault", wb_fault, e.flt);
        check("wb32_regwrite", wb_regwrite, e.rw);
        check("wb32_rd", wb_rd, e.rd);
        check("wb32_alu", wb_alu, e.alu);
        check("wb32_pcp4", wb_pcp4, e.alu + 32'd4);
        if (e.chk_ld) check("wb32_ldata", wb_ldata, e.ld);
      end
    end
  end

  always @(negedge clk) begin : mon64
    exp_t e;
    if (!rst && w_wb_valid) begin
      if (q64.size() == 0) check("wb64_unexpected", w_wb_valid, 1'b0);
      else begin
        e = q64.pop_front();
        check("wb64_fault", w_wb_fault, e.flt);
        check("wb64_regwrite", w_wb_regwrite, e.rw);
        check("wb64_alu", w_wb_alu, e.alu);
        if (e.chk_ld) check("wb64_ldata", w_wb_ldata, e.ld);
      end
    end
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: simulation did not finish, observed hang expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    rst = 1'b1; flush = 1'b0; dbusy = 1'b0; dready_n = 1'b1;
    in_valid = 1'b0; w_in_valid = 1'b0; in_op = OP_NONE; in_funct3 = 3'd0;
    in_addr = 32'h0; in_wdata = 32'h0; w_in_wdata = 64'h0; in_rd = 5'd0;
    in_regwrite = 1'b0; in_memtoreg = 2'b01; in_pcp4 = 32'h0;
    drdata = 32'h0; w_drdata = 64'h0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_dreq", dreq, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_fault", wb_fault, 2'd0);
    check("rst_wb_ldata", wb_ldata, 32'h0);
    check("rst_dbe", dbe, 4'h0);
    rst = 1'b0;
    @(negedge clk);

    // LB at 0x1003: sign-extended top byte, wb_valid on the third cycle
    expect_wb(1'b0, 64'hFFFF_FF80, 1'b1, FLT_NONE, 1'b1, 5'd5, 32'h1003);
    drdata = 32'h80FF_FF11;
    issue(1'b0, OP_LOAD, F3_B, 32'h1003, 64'h0, 5'd5, 1'b1);
    check("lb_dreq", dreq, 1'b1);
    check("lb_daddr", daddr, 32'h1000);
    check("lb_dwrite", dwrite, 1'b0);
    check("lb_wb_c1", wb_valid, 1'b0);
    @(negedge clk);
    check("lb_wb_c2", wb_valid, 1'b0);
    dready_n = 1'b0;
    @(negedge clk);
    check("lb_wb_c3", wb_valid, 1'b1);
    check("lb_ldata", wb_ldata, 32'hFFFF_FF80);
    dready_n = 1'b1;

    do_load32(F3_BU, 32'h1003, 32'h80FF_FF11, 32'h0000_0080);
    do_load32(F3_B,  32'h1000, 32'h80FF_FF11, 32'h0000_0011);
    do_load32(F3_H,  32'h1002, 32'h80FF_FF11, 32'hFFFF_80FF);
    do_load32(F3_HU, 32'h1000, 32'h80FF_FF11, 32'h0000_FF11);
    do_load32(F3_W,  32'h1000, 32'h80FF_FF11, 32'h80FF_FF11);

    // SH at 0x2002: replicated halfword, upper strobes
    expect_wb(1'b0, 64'h0, 1'b0, FLT_NONE, 1'b0, 5'd7, 32'h2002);
    issue(1'b0, OP_STORE, F3_H, 32'h2002, 64'h0000_BEEF, 5'd7, 1'b1);
    check("sh_dreq", dreq, 1'b1);
    check("sh_dwrite", dwrite, 1'b1);
    check("sh_dwdata", dwdata, 32'hBEEF_BEEF);
    check("sh_dbe", dbe, 4'b1100);
    check("sh_daddr", daddr, 32'h2000);
    check("sh_dsize", dsize, 2'd1);
    @(negedge clk);

    do_fault(OP_LOAD,  F3_W, 32'h3001, FLT_MISALIGN);
    do_fault(OP_LOAD,  F3_H, 32'h3001, FLT_MISALIGN);
    do_fault(OP_STORE, F3_W, 32'h3006, FLT_MISALIGN);
    do_fault(OP_LOAD,  F3_D, 32'h3000, FLT_SIZE);
    do_fault(OP_LOAD,  F3_WU, 32'h3000, FLT_SIZE);
    do_fault(OP_LOAD,  3'b111, 32'h3000, FLT_SIZE);
    do_fault(OP_STORE, F3_BU, 32'h3000, FLT_SIZE);

    // LW held off by dbusy for four cycles
    expect_wb(1'b0, 64'h1234_5678, 1'b1, FLT_NONE, 1'b1, 5'd9, 32'h4000);
    drdata = 32'h1234_5678;
    dbusy = 1'b1;
    issue(1'b0, OP_LOAD, F3_W, 32'h4000, 64'h0, 5'd9, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      check("busy_dreq", dreq, 1'b1);
      check("busy_daddr", daddr, 32'h4000);
      if (i == 5) dbusy = 1'b0;
      @(negedge clk);
    end
    check("busy_wait_dreq", dreq, 1'b0);
    check("busy_wait_ready", in_ready, 1'b0);
    dready_n = 1'b0;
    @(negedge clk);
    dready_n = 1'b1;

    // no read data: bus timeout after 8 WAIT cycles
    expect_wb(1'b0, 64'h0, 1'b0, FLT_BUS, 1'b0, 5'd11, 32'h5000);
    issue(1'b0, OP_LOAD, F3_W, 32'h5000, 64'h0, 5'd11, 1'b1);
    repeat (8) @(negedge clk);
    check("to_still_wait", in_ready, 1'b0);
    check("to_no_wb_yet", wb_valid, 1'b0);
    @(negedge clk);
    check("to_idle", in_ready, 1'b1);
    check("to_wb_valid", wb_valid, 1'b1);

    // flush in WAIT: late data is swallowed
    issue(1'b0, OP_LOAD, F3_W, 32'h6000, 64'h0, 5'd12, 1'b1);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check("fw_hold_wait", in_ready, 1'b0);
    @(negedge clk); dready_n = 1'b0;
    @(negedge clk); dready_n = 1'b1;
    check("fw_ready", in_ready, 1'b1);
    check("fw_no_wb", wb_valid, 1'b0);
    expect_wb(1'b0, 64'h0, 1'b0, FLT_NONE, 1'b1, 5'd3, 32'h0000_DEAD);
    issue(1'b0, OP_NONE, 3'd0, 32'h0000_DEAD, 64'h0, 5'd3, 1'b1);
    check("none_wb_valid", wb_valid, 1'b1);

    // flush together with in_valid in IDLE: nothing accepted
    in_op = OP_LOAD; in_funct3 = F3_W; in_addr = 32'h6100; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("fi_no_dreq", dreq, 1'b0);
    check("fi_ready", in_ready, 1'b1);

    // flush in REQ while busy: request dropped
    dbusy = 1'b1;
    issue(1'b0, OP_LOAD, F3_W, 32'h7000, 64'h0, 5'd13, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; dbusy = 1'b0;
    check("fr_dreq_drop", dreq, 1'b0);
    check("fr_ready", in_ready, 1'b1);

    // flush in REQ on the accepting cycle of a store: no writeback
    issue(1'b0, OP_STORE, F3_W, 32'h7004, 64'hCAFE_F00D, 5'd14, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fs_ready", in_ready, 1'b1);
    check("fs_no_wb", wb_valid, 1'b0);

    // reset while in WAIT abandons the load; later data pulse ignored
    issue(1'b0, OP_LOAD, F3_W, 32'h7100, 64'h0, 5'd15, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rw_ready", in_ready, 1'b1);
    dready_n = 1'b0;
    @(negedge clk); dready_n = 1'b1;
    check("rw_no_wb", wb_valid, 1'b0);

    // 64-bit instance
    expect_wb(1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, FLT_NONE, 1'b1, 5'd20, 32'h8);
    w_drdata = 64'h0123_4567_89AB_CDEF;
    issue(1'b1, OP_LOAD, F3_D, 32'h8, 64'h0, 5'd20, 1'b1);
    check("ld64_dreq", w_dreq, 1'b1);
    check("ld64_daddr", w_daddr, 32'h8);
    check("ld64_dsize", w_dsize, 2'd3);
    @(negedge clk); dready_n = 1'b0;
    @(negedge clk); dready_n = 1'b1;

    expect_wb(1'b1, 64'hFFFF_FFFF_8000_0000, 1'b1, FLT_NONE, 1'b1, 5'd21, 32'hC);
    w_drdata = 64'h8000_0000_1234_5678;
    issue(1'b1, OP_LOAD, F3_W, 32'hC, 64'h0, 5'd21, 1'b1);
    @(negedge clk); dready_n = 1'b0;
    @(negedge clk); dready_n = 1'b1;

    expect_wb(1'b1, 64'h0000_0000_8000_0000, 1'b1, FLT_NONE, 1'b1, 5'd22, 32'h1C);
    issue(1'b1, OP_LOAD, F3_WU, 32'h1C, 64'h0, 5'd22, 1'b1);
    @(negedge clk); dready_n = 1'b0;
    @(negedge clk); dready_n = 1'b1;

    expect_wb(1'b1, 64'h0, 1'b0, FLT_NONE, 1'b0, 5'd23, 32'h105);
    issue(1'b1, OP_STORE, F3_B, 32'h105, 64'h0000_00A5, 5'd23, 1'b1);
    check("sb64_dbe", w_dbe, 8'b0010_0000);
    check("sb64_dwdata", w_dwdata, 64'hA5A5_A5A5_A5A5_A5A5);
    check("sb64_daddr", w_daddr, 32'h100);
    @(negedge clk);

    for (int i = 0; i < 20 && (q32.size() + q64.size()) != 0; i++) @(negedge clk);
    check("sb_drained", 64'(q32.size() + q64.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
